controle_partida: RTL and testbench

//  Match sequencer for the two-player duel; drives the pontuacao scoreboard.

---
 rtl/duel_pkg.sv | 11 +
 rtl/pausa_timer.sv | 29 ++
 rtl/controle_partida.sv | 128 ++++++++++++
 tb/tb_controle_partida.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duel_pkg.sv
// Shared types for the two-player duel: match FSM states, winner codes and the scoreboard limit.
package duel_pkg;

  typedef enum logic [2:0] {IDLE, ROUND, SCORE, PAUSE, DONE} match_state_t;

  typedef enum logic [1:0] {W_NONE = 2'b00, W_P1 = 2'b01, W_P2 = 2'b10} winner_t;

  // pontuacao shows at most seven lit LEDs per player
  localparam int MAX_POINTS = 7;

endpackage

// File: rtl/pausa_timer.sv
// Inter-round pause down-counter: loads PAUSE_CYCLES-1, counts down and parks at zero.
module pausa_timer #(
  parameter int PAUSE_CYCLES = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(PAUSE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(PAUSE_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/controle_partida.sv
// Match sequencer for the duel: turns round-end hits into single point pulses for pontuacao,
// paces rounds with a pause plus button release, and declares the match winner.
module controle_partida
  import duel_pkg::*;
#(
  parameter int WIN_POINTS   = 7,
  parameter int PAUSE_CYCLES = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic       p1vic,
  output logic       p2vic,
  output logic       score_clr,
  output logic       round_act,
  output logic       match_over,
  output logic [1:0] winner
);

  localparam int WIN_EFF = (WIN_POINTS > MAX_POINTS) ? MAX_POINTS : WIN_POINTS;
  localparam logic [2:0] WIN_CNT = 3'(WIN_EFF);

  match_state_t state, next_state;
  winner_t      who, next_who;
  logic         start_q;
  logic         start_rise;
  logic         clr_req;
  logic         reaches_win;
  logic [2:0]   p1_pts, p2_pts;
  logic         pause_zero;
  logic         pause_load;
  logic         pause_dec;

  assign start_rise = start & ~start_q;

  // IDLE waits one cycle holding score_clr before ROUND; a rise during that cycle is not a new request
  assign clr_req = start_rise &&
                   (((state == IDLE) && !score_clr) || (state == DONE));

  assign reaches_win = (who == W_P1) ? ((p1_pts + 3'd1) == WIN_CNT)
                                     : ((p2_pts + 3'd1) == WIN_CNT);

  always_comb begin
    next_state = state;
    next_who   = who;
    case (state)
      IDLE: begin
        if (score_clr) next_state = ROUND;
      end
      ROUND: begin
        if (p1_hit && p2_hit) begin
          next_state = PAUSE;
        end else if (p1_hit) begin
          next_state = SCORE;
          next_who   = W_P1;
        end else if (p2_hit) begin
          next_state = SCORE;
          next_who   = W_P2;
        end
      end
      SCORE: begin
        next_state = reaches_win ? DONE : PAUSE;
      end
      PAUSE: begin
        if (pause_zero && !p1_hit && !p2_hit) next_state = ROUND;
      end
      DONE: begin
        if (start_rise) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_who   = W_NONE;
      end
    endcase
  end

  assign pause_load = (next_state == PAUSE) && (state != PAUSE);
  assign pause_dec  = (state == PAUSE);

  pausa_timer #(
    .PAUSE_CYCLES(PAUSE_CYCLES)
  ) u_pausa_timer (
    .clock(clock),
    .reset(reset),
    .load (pause_load),
    .dec  (pause_dec),
    .zero (pause_zero)
  );

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      who        <= W_NONE;
      start_q    <= 1'b0;
      p1_pts     <= 3'd0;
      p2_pts     <= 3'd0;
      p1vic      <= 1'b0;
      p2vic      <= 1'b0;
      score_clr  <= 1'b0;
      round_act  <= 1'b0;
      match_over <= 1'b0;
      winner     <= 2'b00;
    end else begin
      state      <= next_state;
      who        <= next_who;
      start_q    <= start;
      score_clr  <= clr_req;
      round_act  <= (next_state == ROUND);
      match_over <= (next_state == DONE);
      p1vic      <= (next_state == SCORE) && (next_who == W_P1);
      p2vic      <= (next_state == SCORE) && (next_who == W_P2);

      if (clr_req) begin
        p1_pts <= 3'd0;
        p2_pts <= 3'd0;
        winner <= W_NONE;
      end else if (state == SCORE) begin
        if (who == W_P1) p1_pts <= p1_pts + 3'd1;
        else             p2_pts <= p2_pts + 3'd1;
        if (reaches_win) winner <= who;
      end
    end
  end

endmodule

// File: tb/tb_controle_partida.sv
// Scoreboard bench for controle_partida: a mode-level reference model predicts pulses and levels,
// a negedge monitor pops and compares them against the DUT.
module tb_controle_partida;

  localparam int WIN   = 3;
  localparam int PAUSE = 4;

  localparam int MD_IDLE  = 0;
  localparam int MD_CLEAR = 1;
  localparam int MD_PLAY  = 2;
  localparam int MD_AWARD = 3;
  localparam int MD_REST  = 4;
  localparam int MD_OVER  = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       p1_hit = 1'b0;
  logic       p2_hit = 1'b0;
  logic       p1vic, p2vic, score_clr, round_act, match_over;
  logic [1:0] winner;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } pulse_t;

  typedef struct {
    logic       round_act;
    logic       match_over;
    logic [1:0] winner;
  } level_t;

  pulse_t pulse_q[$];
  level_t level_q[$];

  int checks = 0;
  int failures = 0;

  int m_mode = MD_IDLE;
  int m_pts[1:2];
  int m_who = 0;
  int m_winner = 0;
  int m_rest = 0;
  int cyc = 0;
  logic m_prev_start = 1'b0;

  controle_partida #(
    .WIN_POINTS  (WIN),
    .PAUSE_CYCLES(PAUSE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .p1_hit    (p1_hit),
    .p2_hit    (p2_hit),
    .p1vic     (p1vic),
    .p2vic     (p2vic),
    .score_clr (score_clr),
    .round_act (round_act),
    .match_over(match_over),
    .winner    (winner)
  );

  always #5 clock = ~clock;

  // Reference model: what the match should be doing after each rising edge
  always @(posedge clock) begin
    logic   rise;
    pulse_t p;
    level_t l;
    cyc++;
    rise = start && !m_prev_start;
    m_prev_start = start;
    if (reset) begin
      m_mode = MD_IDLE;
      m_pts[1] = 0;
      m_pts[2] = 0;
      m_winner = 0;
      m_prev_start = 1'b0;
    end else begin
      case (m_mode)
        MD_IDLE: if (rise) begin
          m_mode = MD_CLEAR;
          m_pts[1] = 0;
          m_pts[2] = 0;
        end
        MD_CLEAR: m_mode = MD_PLAY;
        MD_PLAY: begin
          if (p1_hit && p2_hit) begin
            m_mode = MD_REST;
            m_rest = 0;
          end else if (p1_hit || p2_hit) begin
            m_mode = MD_AWARD;
            m_who = p1_hit ? 1 : 2;
          end
        end
        MD_AWARD: begin
          m_pts[m_who] = m_pts[m_who] + 1;
          if (m_pts[m_who] == WIN) begin
            m_mode = MD_OVER;
            m_winner = m_who;
          end else begin
            m_mode = MD_REST;
            m_rest = 0;
          end
        end
        MD_REST: begin
          m_rest++;
          if (m_rest >= PAUSE && !p1_hit && !p2_hit) m_mode = MD_PLAY;
        end
        MD_OVER: if (rise) begin
          m_mode = MD_CLEAR;
          m_pts[1] = 0;
          m_pts[2] = 0;
          m_winner = 0;
        end
        default: m_mode = MD_IDLE;
      endcase
    end
    l.round_act  = (m_mode == MD_PLAY);
    l.match_over = (m_mode == MD_OVER);
    l.winner     = 2'(m_winner);
    level_q.push_back(l);
    if (m_mode == MD_CLEAR || m_mode == MD_AWARD) begin
      p.cyc  = cyc;
      p.kind = (m_mode == MD_CLEAR) ? 3'b100 : ((m_who == 1) ? 3'b001 : 3'b010);
      pulse_q.push_back(p);
    end
  end

  // Monitor: levels every cycle, pulses whenever the DUT presents one
  always @(negedge clock) begin
    level_t     l;
    pulse_t     p;
    logic [2:0] kind;
    if (level_q.size() > 0) begin
      l = level_q.pop_front();
      checks++;
      if (round_act !== l.round_act || match_over !== l.match_over || winner !== l.winner) begin
        failures++;
        $display("[TB] FAIL levels cyc=%0d got ra=%0b mo=%0b w=%b expected ra=%0b mo=%0b w=%b",
                 cyc, round_act, match_over, winner, l.round_act, l.match_over, l.winner);
      end
    end
    while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
      p = pulse_q.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL missed_pulse cyc=%0d got none expected kind=%b", p.cyc, p.kind);
    end
    kind = {score_clr, p2vic, p1vic};
    if (kind !== 3'b000) begin
      checks++;
      if (pulse_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_pulse cyc=%0d got kind=%b expected none", cyc, kind);
      end else begin
        p = pulse_q.pop_front();
        if (p.kind !== kind || p.cyc != cyc) begin
          failures++;
          $display("[TB] FAIL pulse cyc=%0d got kind=%b expected kind=%b at cyc=%0d",
                   cyc, kind, p.kind, p.cyc);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic s, input logic a, input logic b);
    @(negedge clock);
    start  = s;
    p1_hit = a;
    p2_hit = b;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) apply_stimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_mode(input int target, input string what);
    for (int i = 0; i < 60; i++) begin
      if (m_mode == target) return;
      apply_stimulus(1'b0, 1'b0, 1'b0);
    end
    checks++;
    failures++;
    $display("[TB] FAIL wait_%s got mode=%0d expected mode=%0d", what, m_mode, target);
  endtask

  // Async reset between edges: outputs must drop before the next clock
  task automatic check_output_reset(input string what);
    #2 reset = 1'b1;
    start  = 1'b0;
    p1_hit = 1'b0;
    p2_hit = 1'b0;
    #1;
    checks++;
    if ({p1vic, p2vic, score_clr, round_act, match_over, winner} !== 7'd0) begin
      failures++;
      $display("[TB] FAIL async_reset_%s got %b expected 0000000", what,
               {p1vic, p2vic, score_clr, round_act, match_over, winner});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout cyc=%0d got no finish expected finish", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic s, a, b;
    $display("[TB] start WIN=%0d PAUSE=%0d", WIN, PAUSE);
    idle_cycles(3);
    reset = 1'b0;
    idle_cycles(3);

    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    wait_mode(MD_PLAY, "first_round");

    repeat (10) apply_stimulus(1'b0, 1'b1, 1'b0);
    idle_cycles(8);
    wait_mode(MD_PLAY, "after_p1");

    apply_stimulus(1'b0, 1'b1, 1'b1);
    idle_cycles(2);
    wait_mode(MD_PLAY, "after_tie");

    apply_stimulus(1'b1, 1'b0, 1'b0);
    idle_cycles(2);

    repeat (3) begin
      wait_mode(MD_PLAY, "p2_round");
      apply_stimulus(1'b0, 1'b0, 1'b1);
      idle_cycles(1);
    end
    wait_mode(MD_OVER, "done");
    repeat (5) apply_stimulus(1'b0, 1'b1, 1'b0);
    idle_cycles(2);

    apply_stimulus(1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    wait_mode(MD_PLAY, "restart");

    apply_stimulus(1'b0, 1'b1, 1'b0);
    idle_cycles(1);
    wait_mode(MD_REST, "pause");
    check_output_reset("pause");
    idle_cycles(3);

    apply_stimulus(1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    wait_mode(MD_PLAY, "score_round");
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    if (m_mode == MD_AWARD) check_output_reset("score");
    else wait_mode(MD_AWARD, "score");
    idle_cycles(3);

    s = 1'b0;
    a = 1'b0;
    b = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) s = ~s;
      if ($urandom_range(0, 6) == 0) a = ~a;
      if ($urandom_range(0, 6) == 0) b = ~b;
      apply_stimulus(s, a, b);
    end
    idle_cycles(12);

    checks++;
    if (pulse_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_pulses got %0d expected 0", pulse_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
